// File: rtl/uart_tx.sv
// 8N1 UART transmitter with internal baud counter; optional parity bit under `UART_TX_PARITY_EN`.
// Latency: start bit on tx one cycle after handshake; ready returns 10*DIV (11*DIV with parity) cycles later.
// Backpressure: ready is low for the whole frame; valid/data are ignored until the first IDLE cycle.
module uart_tx #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_chk
      $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_chk
      $error("uart_tx: PARITY_ODD must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             bit_done;

  assign bit_done = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Outputs are computed one cycle ahead so tx/ready/busy come straight from flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_done ? '0 : cnt_q + 1'b1;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (valid && ready_q) begin
          shift_d = data;
          idx_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = (^shift_q) ^ PARITY_ODD[0];
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[idx_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule
